// File: rtl/sdrc_wb_pkg.sv
// Shared types and constants for the SDRAM subsystem Wishbone master.
package sdrc_wb_pkg;

  localparam int unsigned DEF_AW = 26;
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_LW = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {IDLE, BURST, ABORT} state_e;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts cycles spent waiting for an acknowledge; expire_o flags the final allowed cycle.
module wb_ack_watchdog #(
  parameter int unsigned Cycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the same cycle means the slave answered, so no expiry.
  assign expire_o = en_i & ~clr_i & (cnt_q == CW'(Cycles - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 master running single or incrementing-burst cycles from a command port.
module wb_burst_master
  import sdrc_wb_pkg::*;
#(
  parameter  int unsigned AW     = DEF_AW,
  parameter  int unsigned DW     = DEF_DW,
  parameter  int unsigned LW     = DEF_LW,
  parameter  int unsigned TO_CYC = 1024,
  localparam int unsigned SW     = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          init_done,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wr_data,
  input  logic [SW-1:0] wr_sel,
  output logic          wr_pop,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic [2:0]    wb_cti_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i
);

  state_e        state_q, state_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q, done_q;
  logic          in_burst, beat_ack, last_beat, accept, expire;

  assign in_burst  = (state_q == BURST);
  assign beat_ack  = in_burst & wb_ack_i;
  assign last_beat = beat_ack & (rem_q == '0);
  assign cmd_ready = (state_q == IDLE) & init_done & ~wb_rst_i;
  assign accept    = cmd_valid & cmd_ready;

  wb_ack_watchdog #(
    .Cycles (TO_CYC)
  ) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (accept | beat_ack),
    .en_i     (in_burst),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BURST;
      BURST: begin
        if (last_beat) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d = ABORT;
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= cmd_we;
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (beat_ack) begin
        // Address wraps modulo 2^AW by truncation.
        addr_q <= addr_q + AW'(SW);
        rem_q  <= rem_q - LW'(1);
      end
      rd_valid_q <= beat_ack & ~we_q;
      if (beat_ack & ~we_q) begin
        rd_data_q <= wb_dat_i;
      end
      done_q <= last_beat;
    end
  end

  assign wb_cyc_o  = in_burst;
  assign wb_stb_o  = in_burst;
  assign busy      = in_burst;
  assign err       = (state_q == ABORT);
  assign wb_we_o   = in_burst & we_q;
  assign wb_addr_o = addr_q;
  assign wb_cti_o  = !in_burst ? CTI_CLASSIC : ((rem_q == '0) ? CTI_EOB : CTI_INCR);
  assign wb_dat_o  = (in_burst & we_q) ? wr_data : '0;
  assign wb_sel_o  = !in_burst ? '0 : (we_q ? wr_sel : '1);
  assign wr_pop    = beat_ack & we_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed and randomized bench for wb_burst_master against an address/beat reference model.
module tb_wb_burst_master;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_sel;
  logic          wr_pop;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy, done, err;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel;
  logic [2:0]    wb_cti;
  logic          wb_ack;
  logic [DW-1:0] wb_dat_i;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] wdat [256];
  logic [SW-1:0] wsel [256];
  logic [DW-1:0] rdat [256];
  int            gap  [256];

  wb_burst_master #(
    .AW     (AW),
    .DW     (DW),
    .LW     (LW),
    .TO_CYC (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .init_done (init_done),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_sel    (wr_sel),
    .wr_pop    (wr_pop),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wb_cyc_o  (wb_cyc),
    .wb_stb_o  (wb_stb),
    .wb_we_o   (wb_we),
    .wb_addr_o (wb_addr),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel),
    .wb_cti_o  (wb_cti),
    .wb_ack_i  (wb_ack),
    .wb_dat_i  (wb_dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one command; beat i waits gap[i] idle cycles before its ack.
  task automatic run_cmd(input logic we, input logic [AW-1:0] a, input int len);
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] ea;
    exp_rv = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = LW'(len);
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    for (int i = 0; i <= len; i++) begin
      ea = a + AW'(SW * i);
      for (int g = 0; g <= gap[i]; g++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        wb_ack    = (g == gap[i]);
        wb_dat_i  = wb_ack ? rdat[i] : $urandom;
        wr_data   = wdat[i];
        wr_sel    = wsel[i];
        #1;
        chk("cyc", wb_cyc, 1);
        chk("stb", wb_stb, 1);
        chk("busy", busy, 1);
        chk("we", wb_we, we);
        chk("addr", wb_addr, ea);
        chk("cti", wb_cti, (i == len) ? 3'b111 : 3'b010);
        chk("dat_o", wb_dat_o, we ? wdat[i] : 0);
        chk("sel", wb_sel, we ? wsel[i] : 4'hF);
        chk("wr_pop", wr_pop, wb_ack & we);
        chk("rd_valid", rd_valid, exp_rv);
        if (exp_rv) chk("rd_data", rd_data, exp_rd);
        chk("done_mid", done, 0);
        chk("err_mid", err, 0);
        exp_rv = wb_ack & ~we;
        exp_rd = rdat[i];
      end
    end
    @(negedge clk);
    wb_ack = 1'b0;
    #1;
    chk("cyc_end", wb_cyc, 0);
    chk("stb_end", wb_stb, 0);
    chk("busy_end", busy, 0);
    chk("cti_end", wb_cti, 0);
    chk("done", done, 1);
    chk("err_end", err, 0);
    chk("rd_valid_end", rd_valid, exp_rv);
    if (exp_rv) chk("rd_data_end", rd_data, exp_rd);
    chk("cmd_ready_done", cmd_ready, init_done);
  endtask

  task automatic fill(input int len, input int max_gap);
    for (int i = 0; i <= len; i++) begin
      wdat[i] = $urandom;
      wsel[i] = SW'($urandom);
      rdat[i] = $urandom;
      gap[i]  = $urandom_range(0, max_gap);
    end
  endtask

  initial begin
    rst       = 1'b1;
    init_done = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_sel    = '0;
    wb_ack    = 1'b0;
    wb_dat_i  = '0;
    #1;
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_cti", wb_cti, 0);
    chk("rst_rd", {rd_data, rd_valid}, 0);
    chk("rst_flags", {done, err, busy}, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Single write
    wdat[0] = 32'hDEADBEEF; wsel[0] = 4'hF; gap[0] = 0;
    run_cmd(1'b1, 26'h0000040, 0);

    // Eight-beat write burst
    fill(7, 0);
    run_cmd(1'b1, 26'h0000100, 7);

    // Read burst with ack gaps
    rdat[0] = 32'h11; rdat[1] = 32'h22; rdat[2] = 32'h33; rdat[3] = 32'h44;
    gap[0] = 0; gap[1] = 2; gap[2] = 0; gap[3] = 5;
    run_cmd(1'b0, 26'h0000300, 3);

    // Address wrap
    fill(1, 1);
    run_cmd(1'b1, 26'h3FFFFFC, 1);

    // Randomized commands
    for (int n = 0; n < 8; n++) begin
      int            len;
      logic          we;
      logic [AW-1:0] a;
      len = $urandom_range(0, 9);
      we  = 1'($urandom);
      a   = AW'($urandom) & ~AW'(3);
      fill(len, 3);
      run_cmd(we, a, len);
    end

    // Timeout: slave never acks
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h80; cmd_len = 8'd3;
    for (int c = 0; c < int'(TO); c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wb_ack    = 1'b0;
      #1;
      chk("to_cyc_held", wb_cyc, 1);
      chk("to_err_low", err, 0);
    end
    @(negedge clk);
    #1;
    chk("to_cyc_drop", {wb_cyc, wb_stb}, 0);
    chk("to_err", err, 1);
    chk("to_no_done", done, 0);
    chk("to_ready_abort", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("to_err_once", err, 0);
    chk("to_no_done2", done, 0);
    chk("to_ready_back", cmd_ready, 1);

    // init_done low blocks commands
    @(negedge clk);
    init_done = 1'b0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("init_ready_low", cmd_ready, 0);
      chk("init_no_cyc", wb_cyc, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    init_done = 1'b1;

    // Reset during beat 3 of 8
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 26'h200; cmd_len = 8'd7;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wb_ack    = 1'b1;
    end
    @(negedge clk);
    wb_ack = 1'b0;
    #1;
    chk("rst_mid_addr", wb_addr, 26'h20C);
    chk("rst_mid_cyc", wb_cyc, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_drop", {wb_cyc, wb_stb, busy}, 0);
    chk("rst_mid_flags", {done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_flags", {done, err, wb_cyc}, 0);
    end
    wdat[0] = 32'hCAFEF00D; wsel[0] = 4'h3; gap[0] = 1;
    run_cmd(1'b1, 26'h0000010, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone B3 master that drives the SDRAM controller's Wishbone slave port (wb_stb_i/wb_cyc_i/wb_cti_i/wb_ack_o side).
- Accepts single or burst read/write commands on a valid/ready command port and runs them as classic or incrementing-burst Wishbone cycles.
- Streams write data in and read data out, one beat per acknowledge.
- Provides an ack watchdog; used as the traffic initiator in the SDRAM subsystem and as the bench's bus driver.

Parameters:
- AW, 26, Wishbone byte-address width
- DW, 32, Wishbone data width; byte lanes SW = DW/8
- LW, 8, burst-length field width; beats = cmd_len + 1
- TO_CYC, 1024, cycles without wb_ack_i before a burst is aborted

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- init_done  in  1  SDRAM init complete (sdr_init_done); no command accepted while low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  AW  start byte address
- cmd_len  in  LW  beats minus one
- wr_data  in  DW  current write word
- wr_sel  in  SW  current write byte enables
- wr_pop  out  1  current write word consumed; present next word in the following cycle
- rd_data  out  DW  read word
- rd_valid  out  1  rd_data valid, one-cycle pulse per beat
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes
- err  out  1  one-cycle pulse when a burst is aborted by timeout
- wb_cyc_o, wb_stb_o  out  1  bus cycle / strobe
- wb_we_o  out  1  write enable
- wb_addr_o  out  AW  byte address
- wb_dat_o  out  DW  write data
- wb_sel_o  out  SW  byte select
- wb_cti_o  out  3  cycle type
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  DW  read data

Behaviour:
- Reset (async, wb_rst_i=1):
  - state IDLE.
  - All registered outputs 0: cyc, stb, we, addr, sel, cti, rd_data, rd_valid, done, err, busy.
  - cmd_ready = (state==IDLE) & init_done & ~wb_rst_i.
  - Reset mid-burst drops cyc/stb immediately; no done or err pulse is generated.
- States: IDLE, BURST, ABORT.
- IDLE -> BURST on command accept. Registers: we, addr, remaining = cmd_len, timeout counter = 0. Next cycle: cyc = stb = 1, busy = 1.
- wb_cti_o in BURST:
  - 3'b111 when remaining == 0.
  - 3'b010 otherwise.
  - So a single beat (cmd_len = 0) is issued as cti = 111.
- wb_dat_o / wb_sel_o:
  - Combinationally equal to wr_data / wr_sel while in BURST and we = 1.
  - 0 for reads; wb_sel_o = all-ones for reads.
- On each wb_ack_i in BURST:
  - addr += SW, modulo 2^AW (wraps silently).
  - remaining -= 1; timeout counter cleared.
  - Write: wr_pop = wb_ack_i & wb_we_o (combinational, same cycle).
  - Read: rd_data <= wb_dat_i and rd_valid = 1 on the next cycle (latency 1).
- Last beat (ack with remaining == 0):
  - Next cycle: cyc = stb = 0, cti = 0, busy = 0, done = 1 for one cycle, state IDLE.
  - A new command is accepted no earlier than the cycle done is high (back-to-back spacing: one idle bus cycle).
- ack arriving while not in BURST: ignored.
- Timeout:
  - Counter increments each BURST cycle without ack.
  - When it reaches TO_CYC - 1 without ack: BURST -> ABORT.
  - ABORT holds one cycle with cyc = stb = 0 and err = 1, then returns to IDLE. done is not pulsed.
- init_done falling mid-burst: no effect on the running burst; it only blocks new commands.
- rd_valid and done may be high in the same cycle (last read beat).

Decomposition:
- Package sdrc_wb_pkg:
  - cti constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
  - state enum {IDLE, BURST, ABORT}.
  - Default AW/DW/LW.
- Sub-module wb_ack_watchdog: counter with clear, enable and expire output.

Test Plan:
- Single write, addr 0x0000040, data 0xDEADBEEF, sel 0xF, ack one cycle after stb -> cti = 111, one wr_pop, done 1 cycle after ack, cyc low.
- Write burst cmd_len = 7 at 0x0000100 -> 8 acks, wb_addr_o steps 0x100..0x11C, cti = 010 for beats 0-6 and 111 for beat 7, 8 wr_pop pulses, one done.
- Read burst cmd_len = 3 with slave returning 0x11,0x22,0x33,0x44 and ack gaps of 0/2/0/5 cycles -> rd_valid four times with those values, each 1 cycle after its ack.
- Address wrap: start 0x3FFFFFC, cmd_len = 1 -> second beat wb_addr_o = 0x0000000.
- Slave never acks, TO_CYC = 16 -> cyc/stb drop after 16 BURST cycles, err pulses once, no done, cmd_ready returns high.
- init_done = 0 with cmd_valid = 1 -> cmd_ready stays 0. Separately, wb_rst_i asserted mid-burst (beat 3 of 8) -> cyc/stb/busy 0 asynchronously, no done or err, clean single write works after release.
